// File: rtl/fp_mul_out_stage_pkg.sv
// Shared bfloat16 types and constants for the multiplier result stage.
package fp_mul_out_stage_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
    localparam int          BF16_BIAS    = 127;

    // One queue entry: packed product plus its exception flags (19 bits).
    typedef struct packed {
        bf16_t res;
        logic  nv;
        logic  of;
        logic  uf;
    } mul_out_t;

endpackage

// File: rtl/fp_mul_out_stage_bf16_classify.sv
// Combinational bfloat16 operand classifier; subnormals count as zero.
module bf16_classify
    import fp_mul_out_stage_pkg::*;
(
    input  bf16_t     op,
    output fp_class_e cls
);

    // Decode exponent/fraction into one of four classes.
    always_comb begin
        cls = FP_NORM;
        if (op.exp == 8'h00)
            cls = FP_ZERO;
        else if (op.exp == BF16_EXP_MAX)
            cls = (op.frac == 7'h00) ? FP_INF : FP_NAN;
    end

endmodule

// File: rtl/fp_mul_out_stage.sv
// Registered result stage behind the bf16 multiplier core: applies
// special-value/exception overrides and buffers results in a small queue.
module fp_mul_out_stage
    import fp_mul_out_stage_pkg::*;
#(
    parameter int          DEPTH = 2,
    parameter logic [15:0] QNAN  = BF16_QNAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op1_raw,
    input  logic [15:0] op2_raw,
    input  logic        core_sign,
    input  logic [7:0]  core_exp,
    input  logic [6:0]  core_frac,
    input  logic        core_ovf,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_nv,
    output logic        out_of,
    output logic        out_uf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // Biased exponent-sum limits: below 1 after unbiasing, or past 254.
    localparam logic [8:0] UF_LIM = 9'(BF16_BIAS - 1);
    localparam logic [8:0] OF_LIM = 9'(3 * BF16_BIAS + 1);

    bf16_t     op1, op2;
    fp_class_e cls1, cls2;
    logic [8:0] exp_sum;
    mul_out_t  nxt;

    assign op1     = op1_raw;
    assign op2     = op2_raw;
    assign exp_sum = {1'b0, op1.exp} + {1'b0, op2.exp};

    bf16_classify u_cls1 (.op(op1), .cls(cls1));
    bf16_classify u_cls2 (.op(op2), .cls(cls2));

    // Result override priority; the core result passes only if nothing else applies.
    always_comb begin
        nxt     = '0;
        nxt.res = {core_sign, core_exp, core_frac};
        if (cls1 == FP_NAN || cls2 == FP_NAN ||
            (cls1 == FP_ZERO && cls2 == FP_INF) ||
            (cls1 == FP_INF && cls2 == FP_ZERO)) begin
            nxt.res = bf16_t'(QNAN);
            nxt.nv  = 1'b1;
        end else if (cls1 == FP_INF || cls2 == FP_INF) begin
            nxt.res = {core_sign, BF16_EXP_MAX, 7'h00};
        end else if (cls1 == FP_ZERO || cls2 == FP_ZERO) begin
            nxt.res = {core_sign, 8'h00, 7'h00};
        end else if (exp_sum <= UF_LIM) begin
            // Wrap-under also raises core_ovf, so underflow must win here.
            nxt.res = {core_sign, 8'h00, 7'h00};
            nxt.uf  = 1'b1;
        end else if (exp_sum >= OF_LIM || core_exp == BF16_EXP_MAX || core_ovf) begin
            nxt.res = {core_sign, BF16_EXP_MAX, 7'h00};
            nxt.of  = 1'b1;
        end else if (core_exp == 8'h00) begin
            nxt.res = {core_sign, 8'h00, 7'h00};
            nxt.uf  = 1'b1;
        end
    end

    mul_out_t         mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    mul_out_t         head;

    // Handshakes come from the registered count only: no in->out or
    // out_ready->in_ready combinational path.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Queue storage, pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= nxt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign out_result = head.res;
    assign out_nv     = head.nv;
    assign out_of     = head.of;
    assign out_uf     = head.uf;

endmodule

// File: tb/tb_fp_mul_out_stage.sv
// Scoreboard bench for fp_mul_out_stage: accepted beats push an expected
// result computed from the bf16 rules; a monitor pops on each handshake.
module tb_fp_mul_out_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] op1_raw, op2_raw;
    logic        core_sign;
    logic [7:0]  core_exp;
    logic [6:0]  core_frac;
    logic        core_ovf, flush;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic        out_nv, out_of, out_uf;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb[$];
    logic rnd_en = 1'b0;
    logic ready_force = 1'b1;

    always #5 clk = ~clk;

    fp_mul_out_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1_raw(op1_raw), .op2_raw(op2_raw), .core_sign(core_sign),
        .core_exp(core_exp), .core_frac(core_frac), .core_ovf(core_ovf),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_nv(out_nv), .out_of(out_of), .out_uf(out_uf)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: bf16 multiply exception rules, returns {result, nv, of, uf}.
    function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cs, input logic [7:0] ce,
                                              input logic [6:0] cf, input logic co);
        logic [9:0] ea, eb, sum;
        bit za, zb, ia, ib, na, nb;
        ea = {2'b0, a[14:7]};
        eb = {2'b0, b[14:7]};
        sum = ea + eb;
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == 255) && (a[6:0] == 0);  ib = (eb == 255) && (b[6:0] == 0);
        na = (ea == 255) && (a[6:0] != 0);  nb = (eb == 255) && (b[6:0] != 0);
        if (na || nb || (za && ib) || (ia && zb)) return {16'h7FC0, 3'b100};
        if (ia || ib) return {cs, 8'hFF, 7'd0, 3'b000};
        if (za || zb) return {cs, 15'd0, 3'b000};
        if (sum <= 10'd126) return {cs, 15'd0, 3'b001};
        if (sum >= 10'd382 || ce == 8'hFF || co) return {cs, 8'hFF, 7'd0, 3'b010};
        if (ce == 8'h00) return {cs, 15'd0, 3'b001};
        return {cs, ce, cf, 3'b000};
    endfunction

    // Scoreboard: occupancy-derived handshake checks, pop/compare, then record accepts.
    always @(negedge clk) begin
        logic [18:0] exp_v;
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() > 0) begin
                    exp_v = sb.pop_front();
                    chk("result", 32'({out_result, out_nv, out_of, out_uf}), 32'(exp_v));
                end
                if (in_valid && in_ready)
                    sb.push_back(ref_model(op1_raw, op2_raw, core_sign, core_exp, core_frac, core_ovf));
            end
        end
    end

    always @(negedge rst_n) sb.delete();

    // Sole writer of out_ready: random during the soak, forced otherwise.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cs,
                        input logic [7:0] ce, input logic [6:0] cf, input logic co);
        int n = 0;
        in_valid = 1'b1;
        op1_raw = a;  op2_raw = b;
        core_sign = cs;  core_exp = ce;  core_frac = cf;  core_ovf = co;
        @(negedge clk);
        while (!in_ready) begin
            if (++n > 200) begin
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 8))
            0: e = 8'h00;  1: e = 8'h01;  2: e = 8'h3F;  3: e = 8'h7F;
            4: e = 8'h80;  5: e = 8'hBF;  6: e = 8'hFE;  7: e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'h00};
    endfunction

    initial begin
        rst_n = 1'b0;  in_valid = 1'b0;  flush = 1'b0;  out_ready = 1'b1;
        op1_raw = '0;  op2_raw = '0;  core_sign = 1'b0;  core_exp = '0;
        core_frac = '0;  core_ovf = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'({out_result, out_nv, out_of, out_uf}), 32'd0);
        #10 rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed specials and exponent-sum boundaries.
        send(16'h3F80, 16'h4000, 1'b0, 8'h80, 7'h00, 1'b0);  // 1*2
        send(16'h7F80, 16'h0000, 1'b0, 8'h00, 7'h00, 1'b0);  // inf*0
        send(16'h7FC1, 16'h3F80, 1'b0, 8'h80, 7'h00, 1'b0);  // NaN
        send(16'hFF80, 16'h4000, 1'b1, 8'h80, 7'h00, 1'b0);  // -inf*2
        send(16'h7F00, 16'h7F00, 1'b0, 8'hFE, 7'h00, 1'b1);  // overflow
        send(16'h0080, 16'h0080, 1'b0, 8'h82, 7'h00, 1'b1);  // wrap-under
        send(16'h1F80, 16'h1F80, 1'b0, 8'h00, 7'h00, 1'b0);  // sum=126
        send(16'h1F80, 16'h2000, 1'b0, 8'h01, 7'h05, 1'b0);  // sum=127
        send(16'h5F80, 16'h5F80, 1'b0, 8'hFE, 7'h00, 1'b0);  // sum=382
        send(16'h5F80, 16'h5F00, 1'b0, 8'hFE, 7'h7F, 1'b0);  // sum=381
        send(16'h3F80, 16'h3F80, 1'b0, 8'hFF, 7'h00, 1'b0);  // core exp FF
        send(16'h3F80, 16'h3F80, 1'b1, 8'h00, 7'h00, 1'b0);  // core exp 00
        send(16'h8000, 16'h3F80, 1'b1, 8'h00, 7'h00, 1'b0);  // -0*1
        send(16'h0001, 16'h3F80, 1'b0, 8'h00, 7'h00, 1'b0);  // subnormal
        drain();

        // Backpressure: third beat must be held until the consumer drains.
        ready_force = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                send(16'h3F80, 16'h4040, 1'b0, 8'h80, 7'h40, 1'b0);
                send(16'h4000, 16'h4040, 1'b0, 8'h81, 7'h40, 1'b0);
                send(16'h4040, 16'h4040, 1'b0, 8'h82, 7'h10, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_held", 32'(in_valid), 32'd1);
                ready_force = 1'b1;
            end
        join
        drain();

        // Streaming at count 1: push and pop every cycle.
        for (int i = 0; i < 6; i++)
            send(16'h3F80, 16'h3F80, 1'b0, 8'(8'h7F + i), 7'(i), 1'b0);
        drain();

        // Flush with a same-cycle push: both entries and the push vanish.
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(16'h3F80, 16'h4000, 1'b0, 8'h80, 7'h00, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 8'h81, 7'h00, 1'b0);
        in_valid = 1'b1;  flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;  flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        ready_force = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Mid-cycle asynchronous reset with a full queue.
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(16'h3F80, 16'h4000, 1'b0, 8'h80, 7'h00, 1'b0);
        send(16'h7F00, 16'h7F00, 1'b0, 8'hFE, 7'h00, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_word", 32'({out_result, out_nv, out_of, out_uf}), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 chk("arst_in_ready", 32'(in_ready), 32'd1);
        ready_force = 1'b1;
        @(posedge clk); #1;

        // Random soak with random consumer back-pressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(rand_op(), rand_op(), 1'($urandom),
                 ($urandom_range(0, 5) == 0) ? 8'h00 : (($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom)),
                 7'($urandom), ($urandom_range(0, 7) == 0));
        end
        rnd_en = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_out_stage.md
Name: fp_mul_out_stage

Overview:
- Registered result stage directly downstream of the combinational bfloat16 multiplier core.
- Consumes the core's op3 sign/exp/frac and overflow, plus the raw packed operands.
- Applies special-value and exception overrides (zero, inf, NaN, overflow, underflow flush).
- Buffers results in a 2-entry valid/ready output queue so the issuing stage can be back-pressured.

Parameters:
DEPTH, 2, output queue entries (power of two, >=2)
QNAN, 16'h7FC0, canonical quiet NaN pattern returned for invalid operations

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and core result valid this cycle
in_ready  out  1  stage can accept (queue not full)
op1_raw  in  16  packed bfloat16 operand 1 {sign,exp[7:0],frac[6:0]}
op2_raw  in  16  packed bfloat16 operand 2
core_sign  in  1  multiplier op3_sign
core_exp  in  8  multiplier op3_exp
core_frac  in  7  multiplier op3_frac
core_ovf  in  1  multiplier overflow
flush  in  1  synchronous queue clear
out_valid  out  1  result at queue head valid
out_ready  in  1  consumer accepts head
out_result  out  16  packed bfloat16 product
out_nv  out  1  invalid-operation flag (NaN operand or 0*inf)
out_of  out  1  overflow flag
out_uf  out  1  underflow/flush-to-zero flag

Behaviour:
- Reset (rst_n low, asynchronous): queue empty, pointers and count 0; out_valid=0, out_result=0, out_nv=out_of=out_uf=0; in_ready=1 after reset release.
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Latency: accepted beat appears at out_valid the next cycle if the queue was empty. No combinational in->out path.
- in_ready = (count != DEPTH). It is registered-count based, so there is no out_ready->in_ready combinational path.
- Full with simultaneous push and pop: the push is refused, because in_ready=0.
- Simultaneous push and pop at count 1..DEPTH-1: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Empty: out_valid=0. out_result/flags hold the last-written entry at the head pointer (don't-care to the consumer).
- flush: count and pointers cleared next cycle, any same-cycle push is dropped, and out_valid=0 next cycle. flush has priority over push and pop.
- Classification per operand (exp=e, frac=f):
  - e==0 -> ZERO (subnormals flushed, sign kept)
  - e==FF and f==0 -> INF
  - e==FF and f!=0 -> NAN
  - otherwise NORM
- Exponent sum: sum = e1 + e2, 9-bit unsigned. sgn = core_sign.
- Result priority (first match wins):
  1. Either operand NAN, or ZERO*INF -> QNAN, nv=1.
  2. Either INF -> {sgn, FF, 0}.
  3. Either ZERO -> {sgn, 00, 0}.
  4. sum <= 126 -> {sgn, 00, 0}, uf=1. This overrides core_ovf, which is also set on exponent wrap-under.
  5. sum >= 382, or core_exp == FF, or core_ovf -> {sgn, FF, 0}, of=1.
  6. core_exp == 00 -> {sgn, 00, 0}, uf=1.
  7. Else {core_sign, core_exp, core_frac}.
- Flags are stored per entry alongside the result. They are not sticky.
- Result is computed combinationally at input and written into the queue entry. The queue holds 19 bits per entry.
- Input hold: in_valid deasserted while in_ready=0 is legal. Inputs are sampled only on accept.

Decomposition:
- data_type_pkg additions:
  - bf16_t packed struct {sign, exp[7:0], frac[6:0]}
  - fp_class_e enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - constants BF16_QNAN=16'h7FC0, BF16_EXP_MAX=8'hFF, BF16_BIAS=127
  - mul_out_t struct {bf16_t res; logic nv, of, uf}
- One sub-module, bf16_classify: combinational, bf16_t in -> fp_class_e out. Instantiated twice.
- Queue logic is inline in fp_mul_out_stage.

Test Plan:
- Normal product: op1=3F80 (1.0), op2=4000 (2.0), core {0,80,00}, ovf=0 -> out_result=4000 one cycle after accept, all flags 0.
- Specials:
  - op1=7F80 (inf), op2=0000 -> 7FC0, nv=1.
  - op1=7FC1 (NaN), op2=3F80 -> 7FC0, nv=1.
  - op1=FF80 (-inf), op2=4000 with core_sign=1 -> FF80, flags 0.
- Overflow: op1=op2=7F00 (sum=254+254=508), core_ovf=1 -> 7F80, of=1.
- Underflow: op1=op2=0080 (sum=2), core_ovf=1 (wrap-under) -> 0000, uf=1, of=0.
- Backpressure: out_ready=0, push 3 beats A, B, C -> in_ready=0 after 2 accepts and C held. Raise out_ready -> A, B, C emerge in order, no loss or duplicate. Simultaneous push/pop at count=1 holds count=1.
- Reset and flush:
  - Fill 2 entries, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed beat dropped.
  - Repeat with rst_n asserted mid-cycle -> outputs cleared immediately (asynchronously).
